// File: rtl/cnt8_pkg.sv
// ============================================================================
// Module      : cnt8_pkg
// Description : Shared types and constants for the 8-bit reload timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt8_pkg;

    localparam int WIDTH = 8;

    typedef logic [WIDTH-1:0] cnt_t;

    localparam cnt_t ALL_ONES = '1;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } tmr_state_e;

endpackage

`default_nettype wire

// File: rtl/cnt8_next_state.sv
// ============================================================================
// Module      : cnt8_next_state
// Description : Combinational load/count/reload next-state logic with
//               hold-when-idle and terminal-count detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt8_next_state
    import cnt8_pkg::*;
(
    input  cnt_t count,
    input  logic load,
    input  cnt_t load_data,
    input  logic active,
    input  cnt_t reload_val,
    input  logic halted,
    output cnt_t next_count,
    output logic tc
);

    always_comb begin
        next_count = count;
        tc         = 1'b0;
        if (load) begin
            next_count = load_data;
        end else if (!halted && active) begin
            if (count == ALL_ONES) begin
                next_count = reload_val;
                tc         = 1'b1;
            end else begin
                next_count = count + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cnt8_reload_timer.sv
// ============================================================================
// Module      : cnt8_reload_timer
// Description : Registered 8-bit auto-reload counter with one-shot mode,
//               sticky acknowledged event flag and missed-event counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt8_reload_timer #(
    parameter int WIDTH  = 8,
    parameter int MISS_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              cnt_en,
    input  logic              inhibit,
    input  logic              reload_wr,
    input  logic [WIDTH-1:0]  reload_data,
    input  logic              oneshot,
    input  logic              evt_ack,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              tc_pulse,
    output logic              evt_flag,
    output logic [MISS_W-1:0] miss_cnt,
    output logic              halted
);

    import cnt8_pkg::*;

    localparam logic [MISS_W-1:0] C_MISS_MAX = '1;

    tmr_state_e        r_state;
    tmr_state_e        w_state_next;
    logic [WIDTH-1:0]  r_count;
    logic [WIDTH-1:0]  r_reload;
    logic              r_tc_pulse;
    logic              r_evt_flag;
    logic [MISS_W-1:0] r_miss_cnt;
    logic [WIDTH-1:0]  w_next_count;
    logic              w_tc;
    logic              w_halted;
    logic              w_active;

    assign w_halted = (r_state == HALT);
    assign w_active = cnt_en & ~inhibit;

    cnt8_next_state u_next_state (
        .count      (r_count),
        .load       (load),
        .load_data  (load_data),
        .active     (w_active),
        .reload_val (r_reload),
        .halted     (w_halted),
        .next_count (w_next_count),
        .tc         (w_tc)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (w_tc && oneshot) w_state_next = HALT;
            HALT:    if (load)            w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_count    <= '0;
            r_reload   <= '0;
            r_tc_pulse <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_next_count;
            r_tc_pulse <= w_tc;
            // A write landing on a reload edge only affects the next reload.
            if (reload_wr) begin
                r_reload <= reload_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_flag <= 1'b0;
            r_miss_cnt <= '0;
        end else begin
            if (w_tc) begin
                r_evt_flag <= 1'b1;
            end else if (evt_ack) begin
                r_evt_flag <= 1'b0;
            end

            // An ack arriving with a new event retires the old one, so no miss.
            if (load) begin
                r_miss_cnt <= '0;
            end else if (w_tc && r_evt_flag && !evt_ack && (r_miss_cnt != C_MISS_MAX)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign count    = r_count;
    assign tc       = w_tc;
    assign tc_pulse = r_tc_pulse;
    assign evt_flag = r_evt_flag;
    assign miss_cnt = r_miss_cnt;
    assign halted   = w_halted;

endmodule

`default_nettype wire

// File: tb/tb_cnt8_reload_timer.sv
// ============================================================================
// Module      : tb_cnt8_reload_timer
// Description : Directed self-checking bench for cnt8_reload_timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt8_reload_timer;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [7:0] load_data;
    logic       cnt_en;
    logic       inhibit;
    logic       reload_wr;
    logic [7:0] reload_data;
    logic       oneshot;
    logic       evt_ack;
    logic [7:0] count;
    logic       tc;
    logic       tc_pulse;
    logic       evt_flag;
    logic [3:0] miss_cnt;
    logic       halted;

    int checks   = 0;
    int failures = 0;

    cnt8_reload_timer #(
        .WIDTH  (8),
        .MISS_W (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_data   (load_data),
        .cnt_en      (cnt_en),
        .inhibit     (inhibit),
        .reload_wr   (reload_wr),
        .reload_data (reload_data),
        .oneshot     (oneshot),
        .evt_ack     (evt_ack),
        .count       (count),
        .tc          (tc),
        .tc_pulse    (tc_pulse),
        .evt_flag    (evt_flag),
        .miss_cnt    (miss_cnt),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"},    32'(count),    32'h0);
        check({tag, "_tc_pulse"}, 32'(tc_pulse), 32'h0);
        check({tag, "_evt"},      32'(evt_flag), 32'h0);
        check({tag, "_miss"},     32'(miss_cnt), 32'h0);
        check({tag, "_halted"},   32'(halted),   32'h0);
    endtask

    initial begin : stim
        logic [7:0] exp_cnt;
        logic       prev_tc;
        logic [3:0] exp_miss;

        rst_n = 1'b1; load = 0; load_data = '0; cnt_en = 0; inhibit = 0;
        reload_wr = 0; reload_data = '0; oneshot = 0; evt_ack = 0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("por");
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Reset mid-count, asynchronously between edges
        load = 1; load_data = 8'h37; reload_wr = 1; reload_data = 8'h55;
        tick();
        load = 0; reload_wr = 0;
        check("mid_count", 32'(count), 32'h37);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        // Reload register must also be cleared: FF reloads to 00
        load = 1; load_data = 8'hFF; cnt_en = 1;
        tick();
        load = 0;
        check("rst_reload_ff", 32'(count), 32'hFF);
        tick();
        check("rst_reload_00", 32'(count), 32'h00);

        // Periodic reload from 0xFC
        reload_wr = 1; reload_data = 8'hFC; load = 1; load_data = 8'hFC;
        tick();
        reload_wr = 0; load = 0;
        exp_cnt = 8'hFC;
        prev_tc = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("per_count", 32'(count),    32'(exp_cnt));
            check("per_tc",    32'(tc),       32'(exp_cnt == 8'hFF));
            check("per_pulse", 32'(tc_pulse), 32'(prev_tc));
            prev_tc = (exp_cnt == 8'hFF);
            exp_cnt = (exp_cnt == 8'hFF) ? 8'hFC : exp_cnt + 8'h01;
            tick();
        end

        // Load beats terminal count
        load = 1; load_data = 8'hFF;
        tick();
        load_data = 8'h10;
        check("prio_tc", 32'(tc), 32'h0);
        tick();
        load = 0; cnt_en = 0;
        check("prio_count", 32'(count),    32'h10);
        check("prio_pulse", 32'(tc_pulse), 32'h0);
        check("prio_evt",   32'(evt_flag), 32'h1);
        check("prio_miss",  32'(miss_cnt), 32'h0);
        load = 1; load_data = 8'h20;
        tick();
        load = 0; cnt_en = 1; inhibit = 1;
        tick();
        tick();
        check("inhibit_hold", 32'(count), 32'h20);
        inhibit = 0; cnt_en = 0;
        tick();
        check("disabled_hold", 32'(count), 32'h20);
        evt_ack = 1;
        tick();
        evt_ack = 0;
        check("ack_clear", 32'(evt_flag), 32'h0);

        // One-shot
        reload_wr = 1; reload_data = 8'h00; load = 1; load_data = 8'hFE;
        oneshot = 1; cnt_en = 1;
        tick();
        reload_wr = 0; load = 0;
        check("os_fe", 32'(count), 32'hFE);
        tick();
        check("os_ff", 32'(count), 32'hFF);
        check("os_tc", 32'(tc),    32'h1);
        tick();
        check("os_00",     32'(count),    32'h00);
        check("os_halted", 32'(halted),   32'h1);
        check("os_pulse",  32'(tc_pulse), 32'h1);
        check("os_evt",    32'(evt_flag), 32'h1);
        check("os_miss",   32'(miss_cnt), 32'h0);
        oneshot = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("os_hold_cnt", 32'(count),  32'h00);
            check("os_hold_hlt", 32'(halted), 32'h1);
        end
        load = 1; load_data = 8'h05;
        tick();
        load = 0;
        check("os_rel_cnt", 32'(count),  32'h05);
        check("os_rel_hlt", 32'(halted), 32'h0);
        tick();
        check("os_resume", 32'(count), 32'h06);

        // Missed-event counting, period 2
        reload_wr = 1; reload_data = 8'hFE; load = 1; load_data = 8'hFE; evt_ack = 1;
        tick();
        reload_wr = 0; load = 0; evt_ack = 0;
        check("hs_start_evt", 32'(evt_flag), 32'h0);
        for (int k = 1; k <= 18; k++) begin
            tick();
            tick();
            exp_miss = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
            check("hs_evt",  32'(evt_flag), 32'h1);
            check("hs_miss", 32'(miss_cnt), 32'(exp_miss));
        end

        // Ack colliding with tc keeps flag, no miss increment
        load = 1; load_data = 8'hFE; evt_ack = 1;
        tick();
        load = 0; evt_ack = 0;
        tick(); tick();
        tick(); tick();
        check("col_pre_miss", 32'(miss_cnt), 32'h1);
        tick();
        evt_ack = 1;
        check("col_tc", 32'(tc), 32'h1);
        tick();
        check("col_evt",  32'(evt_flag), 32'h1);
        check("col_miss", 32'(miss_cnt), 32'h1);
        tick();
        evt_ack = 0;
        check("ack_alone", 32'(evt_flag), 32'h0);

        // Reload write on the tc edge uses the old value
        reload_wr = 1; reload_data = 8'h80; load = 1; load_data = 8'hFE;
        tick();
        reload_wr = 0; load = 0;
        tick();
        check("rw_ff", 32'(count), 32'hFF);
        reload_wr = 1; reload_data = 8'h40;
        tick();
        reload_wr = 0;
        check("rw_old", 32'(count), 32'h80);
        repeat (127) tick();
        check("rw_ff2", 32'(count), 32'hFF);
        tick();
        check("rw_new", 32'(count), 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cnt8_reload_timer.md
Name: cnt8_reload_timer

Overview:
- Registered 8-bit up-counter with parallel load and auto-reload on terminal count.
- Sits directly downstream of the team's combinational 8-bit load/count/reload next-state logic.
- Holds the count state, generates the terminal-count pulse, and provides a sticky, acknowledged event flag to the consumer.
- Adds one-shot/periodic mode and a missed-event counter.

Parameters:
- WIDTH, 8, counter/load/reload data width (fixed 8 for this release).
- MISS_W, 4, width of the saturating missed-acknowledge counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  parallel load strobe, highest priority.
- load_data  in  WIDTH  value loaded when load=1.
- cnt_en  in  1  count enable.
- inhibit  in  1  count inhibit; counting occurs only when cnt_en=1 and inhibit=0.
- reload_wr  in  1  write strobe for the reload register.
- reload_data  in  WIDTH  new reload value.
- oneshot  in  1  1 = stop after the first terminal count; 0 = periodic.
- evt_ack  in  1  consumer acknowledge of evt_flag.
- count  out  WIDTH  current counter value.
- tc  out  1  combinational terminal count: count==all-ones AND cnt_en AND !inhibit AND !load AND !halted.
- tc_pulse  out  1  registered one-cycle pulse, asserted the cycle after tc.
- evt_flag  out  1  sticky event flag.
- miss_cnt  out  MISS_W  saturating count of events that occurred while evt_flag was already set.
- halted  out  1  one-shot expiry state.

Behaviour:
- Reset (async, rst_n=0) clears all outputs and registers: count, reload register, tc_pulse, evt_flag, miss_cnt, halted are all 0. Release is synchronous to clk.
- Next-count priority, evaluated every rising edge:
  - 1. load=1: count<=load_data; halted<=0.
  - 2. halted=1: hold.
  - 3. active=(cnt_en & !inhibit): if count==0xFF, count<=reload register (not reload_data); otherwise count<=count+1, modulo 2^WIDTH with no other wrap logic.
  - 4. otherwise: hold. A disabled counter holds its value; it does not clear.
- Reload register: updates on reload_wr. If reload_wr coincides with a terminal-count reload in the same edge, the OLD reload value is used, and the new value takes effect from the next reload.
- tc_pulse: tc_pulse<=tc, giving 1 cycle of latency. Periodic with reload R and continuous enable: one pulse every (256-R) cycles.
- One-shot: when tc=1 and oneshot=1:
  - count still reloads.
  - halted<=1, and the counter freezes until load.
  - oneshot sampled low while halted does not release; only load releases.
- State machine (2 states, encoded by halted):
  - RUN->HALT on tc&oneshot.
  - HALT->RUN on load.
  - Otherwise stay.
- Event flag / handshake:
  - Set: evt_flag<=1 on tc.
  - Clear: evt_flag<=0 on evt_ack when tc=0.
  - tc and evt_ack in the same cycle: the flag stays set (new event wins), and miss_cnt is not incremented.
  - tc while evt_flag=1 and evt_ack=0: miss_cnt<=miss_cnt+1, saturating at 2^MISS_W-1.
  - miss_cnt clears only on reset or load.
  - evt_ack while evt_flag=0 is ignored.
- load and tc are mutually exclusive by the tc definition, so a load on a 0xFF count produces no event.

Decomposition:
- Shared package cnt8_pkg:
  - WIDTH default.
  - ALL_ONES constant.
  - typedef cnt_t (logic [WIDTH-1:0]).
  - Enum tmr_state_e {RUN, HALT}.
- One natural sub-module: cnt8_next_state, purely combinational.
  - Inputs: count, load, load_data, active, reload value, halted.
  - Outputs: next count and tc.
  - It mirrors the existing next-state logic but with hold-when-idle.
- The top level owns all registers, the state machine, the event flag and miss_cnt.

Test Plan:
- Reset mid-count: count=0x37, assert rst_n=0 asynchronously -> all outputs 0 immediately, before any clk edge.
- Periodic reload: reload_wr with 0xFC, load 0xFC, cnt_en=1 -> count sequence FC,FD,FE,FF,FC,...; tc high exactly when count=FF; tc_pulse every 4 cycles.
- Priority: load=1, load_data=0x10 with cnt_en=1 at count=0xFF -> count=0x10, no tc, no tc_pulse, evt_flag unchanged. inhibit=1 at count=0x20 -> count holds 0x20.
- One-shot: reload 0x00, oneshot=1, load 0xFE -> FE,FF,00 then halted=1 and count stays 00 for 10 cycles. Load 0x05 -> halted=0 and counting resumes at 05.
- Handshake/miss: period 2 (reload 0xFE), never ack -> evt_flag=1 and miss_cnt rises 1,2,... saturating at 15. Ack in the same cycle as tc -> evt_flag stays 1 and miss_cnt is unchanged. Ack alone -> evt_flag=0 next cycle.
- Reload write collision: reload=0x80, write 0x40 on the tc edge -> next count 0x80; the following reload yields 0x40.
